// File: rtl/signed_scan_display.sv
// signed_scan_display
//   Converts a signed two's-complement value to sign + BCD with a sequential
//   double-dabble converter, then drives a time-multiplexed 7-segment display.
//   The converter handshakes through load_valid/load_ready. The display
//   register only changes on COMMIT, so scanning never shows a partial result.
//
// Ports
//   clk         system clock, all logic on its rising edge
//   reset       synchronous active-high reset
//   load_valid  request to capture load_data (honoured only while load_ready)
//   load_data   signed value to display, WIDTH bits
//   load_ready  converter idle, a load is accepted on this cycle's edge
//   blank_en    leading-zero blanking enable, applied combinationally
//   seg         active-high segments a..g (bit0..bit6) for the selected position
//   CAT         active-low one-hot position select, bit0 = ones position
//   overflow    committed magnitude does not fit in DIGITS-1 decimal digits
//
// Converter states
//   state  | meaning
//   IDLE   | waiting for load_valid, load_ready high
//   ABS    | split captured value into sign and magnitude, clear BCD
//   SHIFT  | one double-dabble step per cycle, WIDTH cycles
//   COMMIT | copy sign, digits and overflow into the display register

module signed_scan_display #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 78125
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_data,
  output logic              load_ready,
  input  logic              blank_en,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] CAT,
  output logic              overflow
);

  // Number of decimal digits needed to hold 2**w.
  function automatic int digits_for_pow2(int w);
    longint v;
    int     n;
    v = longint'(1) << w;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v > 0) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  localparam int ND     = DIGITS - 1;
  localparam int NB_MIN = digits_for_pow2(WIDTH);
  localparam int NB     = (NB_MIN > ND) ? NB_MIN : ND;
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW     = $clog2(DIGITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ABS,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    in_reg;
  logic                sign_reg;
  logic [WIDTH:0]      mag_reg;
  logic [4*NB-1:0]     bcd_reg;
  logic [CW-1:0]       bit_cnt;

  logic                disp_sign;
  logic [4*ND-1:0]     disp_bcd;
  logic                disp_ovf;

  logic [PW-1:0]       pre_cnt;
  logic [IW-1:0]       pos_idx;

  logic [WIDTH-1:0]    abs_mag;
  logic [4*(NB-1)-1:0] bcd_adj_lo;
  logic [4*NB-1:0]     bcd_next;
  logic                ovf_next;

  // The magnitude of the most-negative input, 2**(WIDTH-1), is exact as an
  // unsigned WIDTH-bit value, so plain two's-complement negation suffices.
  always_comb begin
    abs_mag = in_reg[WIDTH-1] ? (~in_reg + WIDTH'(1)) : in_reg;
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next
  // magnitude bit. The top digit never reaches 5 before its final shift
  // because the BCD register holds 2**WIDTH, so it needs no correction and
  // its MSB is always zero going in.
  always_comb begin
    bcd_adj_lo = bcd_reg[4*(NB-1)-1:0];
    for (int i = 0; i < NB - 1; i++) begin
      if (bcd_reg[4*i +: 4] >= 4'd5) begin
        bcd_adj_lo[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
      end
    end
    bcd_next = {bcd_reg[4*NB-2 : 4*(NB-1)], bcd_adj_lo, mag_reg[WIDTH]};
  end

  always_comb begin
    ovf_next = 1'b0;
    for (int i = ND; i < NB; i++) begin
      if (bcd_reg[4*i +: 4] != 4'd0) begin
        ovf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      load_ready <= 1'b1;
      in_reg     <= '0;
      sign_reg   <= 1'b0;
      mag_reg    <= '0;
      bcd_reg    <= '0;
      bit_cnt    <= '0;
      disp_sign  <= 1'b0;
      disp_bcd   <= '0;
      disp_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            in_reg     <= load_data;
            load_ready <= 1'b0;
            state      <= ST_ABS;
          end
        end
        ST_ABS: begin
          // Zero is non-negative, so negative zero cannot arise.
          sign_reg <= in_reg[WIDTH-1];
          // Left-aligned so the shift always takes the register MSB.
          mag_reg  <= {abs_mag, 1'b0};
          bcd_reg  <= '0;
          bit_cnt  <= CW'(WIDTH);
          state    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bcd_reg <= bcd_next;
          mag_reg <= {mag_reg[WIDTH-1:0], 1'b0};
          bit_cnt <= bit_cnt - CW'(1);
          if (bit_cnt == CW'(1)) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          disp_sign  <= sign_reg;
          disp_bcd   <= bcd_reg[4*ND-1:0];
          disp_ovf   <= ovf_next;
          load_ready <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          load_ready <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Position scan, independent of the converter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      pos_idx <= '0;
    end else if (pre_cnt == PW'(SCAN_DIV - 1)) begin
      pre_cnt <= '0;
      pos_idx <= (pos_idx == IW'(DIGITS - 1)) ? '0 : pos_idx + IW'(1);
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  function automatic logic [6:0] seg_of(logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  logic [3:0] cur_digit;
  logic       upper_zero;

  always_comb begin
    cur_digit  = 4'd0;
    upper_zero = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (IW'(i) == pos_idx) begin
        cur_digit = disp_bcd[4*i +: 4];
      end
      // Position is blankable only if it and everything above it are zero.
      if ((IW'(i) >= pos_idx) && (disp_bcd[4*i +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end

    CAT = ~(DIGITS'(1) << pos_idx);

    if (disp_ovf) begin
      seg = 7'h40;
    end else if (pos_idx == IW'(DIGITS - 1)) begin
      seg = disp_sign ? 7'h40 : 7'h00;
    end else if (blank_en && (pos_idx != '0) && upper_zero) begin
      seg = 7'h00;
    end else begin
      seg = seg_of(cur_digit);
    end
  end

  assign overflow = disp_ovf;

endmodule

// File: tb/tb_signed_scan_display.sv
`timescale 1ns/1ps
module tb_signed_scan_display;

  localparam int W0 = 8,  D0 = 4, S0 = 4;
  localparam int W1 = 12, D1 = 4, S1 = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    load_valid = '0;
  logic [1:0]    blank_en = '1;
  logic [1:0]    load_ready;
  logic [1:0]    overflow;
  logic [W0-1:0] data0 = '0;
  logic [W1-1:0] data1 = '0;
  logic [6:0]    seg0, seg1;
  logic [D0-1:0] cat0;
  logic [D1-1:0] cat1;

  signed_scan_display #(.WIDTH(W0), .DIGITS(D0), .SCAN_DIV(S0)) dut0 (
    .clk(clk), .reset(reset), .load_valid(load_valid[0]), .load_data(data0),
    .load_ready(load_ready[0]), .blank_en(blank_en[0]), .seg(seg0), .CAT(cat0),
    .overflow(overflow[0])
  );

  signed_scan_display #(.WIDTH(W1), .DIGITS(D1), .SCAN_DIV(S1)) dut1 (
    .clk(clk), .reset(reset), .load_valid(load_valid[1]), .load_data(data1),
    .load_ready(load_ready[1]), .blank_en(blank_en[1]), .seg(seg1), .CAT(cat1),
    .overflow(overflow[1])
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state, per instance.
  int m_busy[2]  = '{0, 0};
  int m_pre[2]   = '{0, 0};
  int m_pos[2]   = '{0, 0};
  int m_disp[2]  = '{0, 0};
  bit rst_edge[2] = '{0, 0};
  bit armed[2]    = '{0, 0};
  bit rdy_prev[2] = '{0, 0};
  int q0[$];
  int q1[$];

  function automatic int wd(int k); return (k == 0) ? W0 : W1; endfunction
  function automatic int dg(int k); return (k == 0) ? D0 : D1; endfunction
  function automatic int sd(int k); return (k == 0) ? S0 : S1; endfunction

  function automatic int pow10(int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int iabs(int v); return (v < 0) ? -v : v; endfunction

  function automatic int enc(int d);
    case (d)
      0: return 'h3F;  1: return 'h06;  2: return 'h5B;  3: return 'h4F;
      4: return 'h66;  5: return 'h6D;  6: return 'h7D;  7: return 'h07;
      8: return 'h7F;  9: return 'h6F;  default: return 'h00;
    endcase
  endfunction

  // Expected segments from the displayed value, straight from the display rules.
  function automatic int exp_seg(int v, int digits, int pos, bit be);
    int mag = iabs(v);
    int p10 = pow10(pos);
    if (mag >= pow10(digits - 1)) return 'h40;
    if (pos == digits - 1) return (v < 0) ? 'h40 : 'h00;
    if (be && pos > 0 && mag < p10) return 'h00;
    return enc((mag / p10) % 10);
  endfunction

  task automatic check(string name, int k, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d t=%0t got=%0h expected=%0h", name, k, $time, act, exp);
  endtask

  task automatic push(int k, int v);
    if (k == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  function automatic int qsize(int k); return (k == 0) ? q0.size() : q1.size(); endfunction

  function automatic int pop(int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int seg_of(int k); return (k == 0) ? int'(seg0) : int'(seg1); endfunction
  function automatic int cat_of(int k); return (k == 0) ? int'(cat0) : int'(cat1); endfunction

  // Timing model: scan position and converter busy window, advanced per edge.
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k]   = 0;
        m_pre[k]    = 0;
        m_pos[k]    = 0;
        rst_edge[k] = 1'b1;
        armed[k]    = 1'b1;
      end else begin
        if (m_pre[k] == sd(k) - 1) begin
          m_pre[k] = 0;
          m_pos[k] = (m_pos[k] + 1) % dg(k);
        end else begin
          m_pre[k] = m_pre[k] + 1;
        end
        if (m_busy[k] > 0) m_busy[k] = m_busy[k] - 1;
        else if (load_valid[k]) m_busy[k] = wd(k) + 2;
      end
    end
  end

  // Monitor: pops the scoreboard when a conversion completes, checks outputs.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (armed[k]) begin
        if (rst_edge[k]) begin
          rst_edge[k] = 1'b0;
          m_disp[k] = 0;
          if (k == 0) q0.delete(); else q1.delete();
        end else if (load_ready[k] && !rdy_prev[k]) begin
          if (qsize(k) == 0) check("commit_without_load", k, 0, 1);
          else m_disp[k] = pop(k);
        end
        rdy_prev[k] = load_ready[k];
        check("load_ready", k, int'(load_ready[k]), int'(m_busy[k] == 0));
        check("cat", k, cat_of(k), ((1 << dg(k)) - 1) & ~(1 << m_pos[k]));
        check("overflow", k, int'(overflow[k]), int'(iabs(m_disp[k]) >= pow10(dg(k) - 1)));
        check("seg", k, seg_of(k), exp_seg(m_disp[k], dg(k), m_pos[k], blank_en[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(int k, int v);
    if (k == 0) data0 = W0'(v); else data1 = W1'(v);
  endtask

  task automatic wait_idle(int k);
    for (int n = 0; n < 100 && m_busy[k] != 0; n++) step();
  endtask

  function automatic int rand_val(int k);
    return int'($urandom_range(0, (1 << wd(k)) - 1)) - (1 << (wd(k) - 1));
  endfunction

  // One load, optionally holding load_valid high with changing data through
  // the conversion, then dwell two full scans with blank_en wiggling.
  task automatic do_load(int k, int v, bit be, bit hold);
    wait_idle(k);
    blank_en[k] = be;
    set_data(k, v);
    load_valid[k] = 1'b1;
    push(k, v);
    step();
    if (hold) begin
      for (int i = 0; i < wd(k); i++) begin
        set_data(k, int'($urandom));
        step();
      end
    end
    load_valid[k] = 1'b0;
    wait_idle(k);
    for (int i = 0; i < 2 * dg(k) * sd(k) + 1; i++) begin
      if ($urandom_range(0, 7) == 0) blank_en[k] = ~blank_en[k];
      step();
    end
    blank_en[k] = be;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    fork
      begin
        do_load(0, 5, 1'b1, 1'b0);
        do_load(0, -128, 1'b1, 1'b1);
        do_load(0, 7, 1'b0, 1'b0);
        do_load(0, 0, 1'b1, 1'b0);
        do_load(0, 127, 1'b1, 1'b1);
        do_load(0, -1, 1'b1, 1'b0);
        do_load(0, -100, 1'b0, 1'b0);
        do_load(0, 10, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
          do_load(0, rand_val(0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        do_load(1, 1000, 1'b1, 1'b0);
        do_load(1, -999, 1'b1, 1'b1);
        do_load(1, -2048, 1'b1, 1'b0);
        do_load(1, 2047, 1'b0, 1'b0);
        do_load(1, 999, 1'b1, 1'b0);
        do_load(1, -1000, 1'b1, 1'b1);
        do_load(1, 0, 1'b0, 1'b0);
        do_load(1, 100, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
          do_load(1, rand_val(1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    join

    // Reset lands four cycles into a conversion on both instances.
    wait_idle(0);
    wait_idle(1);
    set_data(0, -77);
    set_data(1, 1234);
    load_valid = 2'b11;
    push(0, -77);
    push(1, 1234);
    step();
    load_valid = 2'b00;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (40) step();

    for (int k = 0; k < 2; k++) check("queue_drained", k, qsize(k), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
